// File: rtl/stream_word_gen.sv
// rtl/stream_word_gen.sv - ap_ctrl_hs stream source emitting an arithmetic word sequence
//
// Once started, emits NUM_WORDS words START_VALUE, START_VALUE+STEP, ...
// (modulo 2^32) on an ap_hs output stream, honouring downstream backpressure.
// It then pulses ap_done/ap_ready and returns to idle.
//
// Ports:
//   ap_clk               single clock, rising edge
//   ap_rst               synchronous reset, active-high
//   ap_start             start request, sampled only while idle
//   ap_done              one-cycle pulse after the last word is accepted
//   ap_idle              high while idle (decoded from state)
//   ap_ready             one-cycle pulse, coincident with ap_done
//   Output_1_V_V         stream data word
//   Output_1_V_V_ap_vld  stream data valid
//   Output_1_V_V_ap_ack  downstream accept
module stream_word_gen #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] START_VALUE = 32'h0000_0000,
  parameter logic [31:0] STEP        = 32'h0000_0001
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack
);

  localparam int unsigned      CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  // All outputs except ap_idle come straight from registers, so no input
  // reaches an output combinationally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        // ap_start is sampled here even in the cycle ap_done is high, which
        // gives the one-cycle gap between back-to-back runs.
        if (ap_start) begin
          state_d = SEND;
          cnt_d   = '0;
          data_d  = START_VALUE;
          vld_d   = 1'b1;
        end
      end
      SEND: begin
        if (Output_1_V_V_ap_ack) begin
          if (cnt_q == LAST_IDX) begin
            // Last word accepted: data holds its final value.
            state_d = IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            data_d = data_q + STEP;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 32'h0000_0000;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign ap_idle             = (state_q == IDLE);
  assign ap_done             = done_q;
  assign ap_ready            = done_q;
  assign Output_1_V_V        = data_q;
  assign Output_1_V_V_ap_vld = vld_q;

endmodule

// File: tb/tb_stream_word_gen.sv
// tb/tb_stream_word_gen.sv - self-checking bench for stream_word_gen
module tb_stream_word_gen;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- instances ----------------
  // a: basic/backpressure/held start, w: wrap-around, r: mid-run reset,
  // s: randomized against the reference model with a wrapping, odd step.
  localparam logic [31:0] S_START = 32'hFFFF_FFF0;
  localparam logic [31:0] S_STEP  = 32'h3000_0007;
  localparam int unsigned S_N     = 5;

  logic        a_rst, a_start, a_ack, a_done, a_idle, a_ready, a_vld;
  logic [31:0] a_data;
  logic        w_rst, w_start, w_ack, w_done, w_idle, w_ready, w_vld;
  logic [31:0] w_data;
  logic        r_rst, r_start, r_ack, r_done, r_idle, r_ready, r_vld;
  logic [31:0] r_data;
  logic        s_rst, s_start, s_ack, s_done, s_idle, s_ready, s_vld;
  logic [31:0] s_data;

  stream_word_gen #(.NUM_WORDS(4), .START_VALUE(32'h0), .STEP(32'h1)) u_a (
    .ap_clk(ap_clk), .ap_rst(a_rst), .ap_start(a_start), .ap_done(a_done),
    .ap_idle(a_idle), .ap_ready(a_ready), .Output_1_V_V(a_data),
    .Output_1_V_V_ap_vld(a_vld), .Output_1_V_V_ap_ack(a_ack));

  stream_word_gen #(.NUM_WORDS(4), .START_VALUE(32'hFFFF_FFFE), .STEP(32'h1)) u_w (
    .ap_clk(ap_clk), .ap_rst(w_rst), .ap_start(w_start), .ap_done(w_done),
    .ap_idle(w_idle), .ap_ready(w_ready), .Output_1_V_V(w_data),
    .Output_1_V_V_ap_vld(w_vld), .Output_1_V_V_ap_ack(w_ack));

  stream_word_gen #(.NUM_WORDS(8), .START_VALUE(32'h0), .STEP(32'h1)) u_r (
    .ap_clk(ap_clk), .ap_rst(r_rst), .ap_start(r_start), .ap_done(r_done),
    .ap_idle(r_idle), .ap_ready(r_ready), .Output_1_V_V(r_data),
    .Output_1_V_V_ap_vld(r_vld), .Output_1_V_V_ap_ack(r_ack));

  stream_word_gen #(.NUM_WORDS(S_N), .START_VALUE(S_START), .STEP(S_STEP)) u_s (
    .ap_clk(ap_clk), .ap_rst(s_rst), .ap_start(s_start), .ap_done(s_done),
    .ap_idle(s_idle), .ap_ready(s_ready), .Output_1_V_V(s_data),
    .Output_1_V_V_ap_vld(s_vld), .Output_1_V_V_ap_ack(s_ack));

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [63:0] pack(logic vld, logic done, logic ready,
                                       logic idle, logic [31:0] data);
    return {28'h0, vld, done, ready, idle, data};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (vld,done,ready,idle,data)", nm, act, exp);
    end
  endtask

  // Reference model: a run is "active" with word index idx; the word shown
  // is always START + idx*STEP computed directly by multiplication.
  typedef struct {
    bit          active;
    int unsigned idx;
    bit          done;
    logic [31:0] data;
  } mstate_t;

  function automatic mstate_t model_step(mstate_t s, bit rst, bit start, bit ack,
                                         int unsigned n, logic [31:0] sv,
                                         logic [31:0] stp);
    mstate_t r = s;
    r.done = 1'b0;
    if (rst) begin
      r.active = 1'b0;
      r.idx    = 0;
      r.data   = 32'h0;
    end else if (!s.active) begin
      if (start) begin
        r.active = 1'b1;
        r.idx    = 0;
        r.data   = sv;
      end
    end else if (ack) begin
      if (s.idx == n - 1) begin
        r.active = 1'b0;
        r.done   = 1'b1;
      end else begin
        r.idx  = s.idx + 1;
        r.data = sv + r.idx * stp;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] mpack(mstate_t m);
    return pack(m.active, m.done, m.done, !m.active, m.data);
  endfunction

  // ---------------- directed table for instance a ----------------
  typedef struct {
    bit          rst, start, ack;
    bit          vld, done, idle;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit start, bit ack, bit vld, bit done,
                              bit idle, logic [31:0] data);
    vec_t v;
    v.rst = rst; v.start = start; v.ack = ack;
    v.vld = vld; v.done = done; v.idle = idle; v.data = data;
    tbl.push_back(v);
  endfunction

  mstate_t     m_a, m_s;
  int          xfers, dones;
  logic [31:0] got[$];
  logic [31:0] wrap_exp[4];

  initial begin
    a_rst = 1; a_start = 0; a_ack = 0;
    w_rst = 1; w_start = 0; w_ack = 0;
    r_rst = 1; r_start = 0; r_ack = 0;
    s_rst = 1; s_start = 0; s_ack = 0;
    m_a = '{active: 1'b0, idx: 0, done: 1'b0, data: 32'h0};
    m_s = m_a;

    // reset held 5 cycles
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 1, 32'd0);
    // basic run, ack high
    add(0, 1, 1, 1, 0, 0, 32'd0);
    add(0, 0, 1, 1, 0, 0, 32'd1);
    add(0, 0, 1, 1, 0, 0, 32'd2);
    add(0, 0, 1, 1, 0, 0, 32'd3);
    add(0, 0, 1, 0, 1, 1, 32'd3);
    add(0, 0, 1, 0, 0, 1, 32'd3);
    add(0, 0, 1, 0, 0, 1, 32'd3);   // ack while idle ignored
    // backpressure on word 1, with a stray start during SEND
    add(0, 1, 0, 1, 0, 0, 32'd0);
    add(0, 0, 1, 1, 0, 0, 32'd1);
    add(0, 0, 0, 1, 0, 0, 32'd1);
    add(0, 1, 0, 1, 0, 0, 32'd1);
    add(0, 0, 0, 1, 0, 0, 32'd1);
    add(0, 0, 1, 1, 0, 0, 32'd2);
    add(0, 0, 1, 1, 0, 0, 32'd3);
    add(0, 0, 1, 0, 1, 1, 32'd3);
    add(0, 0, 0, 0, 0, 1, 32'd3);
    add(0, 0, 0, 0, 0, 1, 32'd3);

    foreach (tbl[i]) begin
      a_rst = tbl[i].rst; a_start = tbl[i].start; a_ack = tbl[i].ack;
      m_a = model_step(m_a, a_rst, a_start, a_ack, 4, 32'h0, 32'h1);
      tick();
      chk($sformatf("table[%0d]", i), pack(a_vld, a_done, a_ready, a_idle, a_data),
          pack(tbl[i].vld, tbl[i].done, tbl[i].done, tbl[i].idle, tbl[i].data));
    end

    // held start: 10 cycles high, two back-to-back runs
    xfers = 0; dones = 0;
    for (int i = 0; i < 14; i++) begin
      a_start = (i < 10); a_ack = 1;
      if (a_vld && a_ack) xfers++;
      m_a = model_step(m_a, 0, a_start, a_ack, 4, 32'h0, 32'h1);
      tick();
      if (a_done) dones++;
      chk($sformatf("held[%0d]", i), pack(a_vld, a_done, a_ready, a_idle, a_data), mpack(m_a));
    end
    chk("held_done_count", 64'(dones), 64'd2);
    chk("held_xfer_count", 64'(xfers), 64'd8);

    // wrap-around
    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;
    w_rst = 0; w_start = 1; w_ack = 1;
    tick();
    w_start = 0;
    dones = 0; got.delete();
    for (int i = 0; i < 8; i++) begin
      if (w_vld && w_ack) got.push_back(w_data);
      tick();
      if (w_done) dones++;
    end
    chk("wrap_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("wrap_word[%0d]", i), 64'(got[i]), 64'(wrap_exp[i]));
    chk("wrap_done_count", 64'(dones), 64'd1);

    // reset mid-run
    r_rst = 0; r_start = 1; r_ack = 0;
    tick();
    chk("midrst_first", pack(r_vld, r_done, r_ready, r_idle, r_data), pack(1, 0, 0, 0, 32'd0));
    r_start = 0; r_ack = 1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (r_done) dones++;
    end
    chk("midrst_word4", pack(r_vld, r_done, r_ready, r_idle, r_data), pack(1, 0, 0, 0, 32'd4));
    r_rst = 1;
    tick();
    chk("midrst_reset", pack(r_vld, r_done, r_ready, r_idle, r_data), pack(0, 0, 0, 1, 32'd0));
    r_rst = 0; r_start = 1;
    tick();
    if (r_done) dones++;
    r_start = 0;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      if (r_vld && r_ack) got.push_back(r_data);
      tick();
      if (r_done) dones++;
    end
    chk("midrst_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) chk($sformatf("midrst_word[%0d]", i), 64'(got[i]), 64'(i));
    chk("midrst_done_count", 64'(dones), 64'd1);

    // randomized against the reference model
    for (int i = 0; i < 800; i++) begin
      s_rst   = (i < 2) || ($urandom_range(63) == 0);
      s_start = ($urandom_range(2) == 0);
      s_ack   = ($urandom_range(3) != 0);
      m_s = model_step(m_s, s_rst, s_start, s_ack, S_N, S_START, S_STEP);
      tick();
      chk($sformatf("rand[%0d]", i), pack(s_vld, s_done, s_ready, s_idle, s_data), mpack(m_s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
